// File: rtl/mips_cpu_state_sequencer.sv
// mips_cpu_state_sequencer
// Multicycle phase sequencer feeding the controller's 3-bit state input.
// Phases: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2, 5 HALT.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   waitrequest       Avalon memory stall
//   memread/memwrite  controller memory strobes for the current phase
//   threecycle        controller: instruction retires in EXEC1
//   pc_zero           datapath: next fetch address is 0 (halt condition)
//   state             current phase
//   active            registered, 1 while executing (phases 1..4)
//   stall             combinational hold of the current phase
//   instr_count       retired instructions (perf build only, else 0)
//   cycle_count       active cycles, stalls included (perf build only, else 0)
//
// Optional feature macro: MIPS_CPU_PERF_COUNTERS_EN builds the counters.
module mips_cpu_state_sequencer #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   waitrequest,
  input  logic                   memread,
  input  logic                   memwrite,
  input  logic                   threecycle,
  input  logic                   pc_zero,
  output logic [2:0]             state,
  output logic                   active,
  output logic                   stall,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t cur, nxt;
  logic   mem_phase;

  assign state = cur;

  // Only phases that can issue a bus access may be held by waitrequest.
  assign mem_phase = (cur == S_FETCH) || (cur == S_EXEC1) || (cur == S_EXEC2);
  assign stall     = (memread | memwrite) & waitrequest & mem_phase;

  always_comb begin
    nxt = S_IDLE;
    if (stall) nxt = cur;
    else begin
      case (cur)
        S_IDLE:   nxt = S_FETCH;
        S_FETCH:  nxt = S_DECODE;
        S_DECODE: nxt = S_EXEC1;
        S_EXEC1:  nxt = threecycle ? (pc_zero ? S_HALT : S_FETCH) : S_EXEC2;
        S_EXEC2:  nxt = pc_zero ? S_HALT : S_FETCH;
        S_HALT:   nxt = S_HALT;
        default:  nxt = S_IDLE;  // 6/7 recover to IDLE
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur    <= S_IDLE;
      active <= 1'b0;
    end else begin
      cur    <= nxt;
      // active follows the phase being entered so it drops with HALT entry
      active <= (nxt == S_FETCH) || (nxt == S_DECODE) ||
                (nxt == S_EXEC1) || (nxt == S_EXEC2);
    end
  end

`ifdef MIPS_CPU_PERF_COUNTERS_EN
  logic retire;

  assign retire = !stall && (((cur == S_EXEC1) && threecycle) || (cur == S_EXEC2));

  // HALT has active=0 and no retire, so both counters freeze there.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      if (retire) instr_count <= instr_count + COUNT_WIDTH'(1);
      if (active) cycle_count <= cycle_count + COUNT_WIDTH'(1);
    end
  end
`else
  assign instr_count = '0;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
module tb_mips_cpu_state_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1, waitrequest = 1'b0, memread = 1'b0, memwrite = 1'b0;
  logic threecycle = 1'b0, pc_zero = 1'b0;
  logic [2:0]  state, state4;
  logic        active, stall, active4, stall4;
  logic [31:0] ic, cc;
  logic [3:0]  ic4, cc4;
  int total = 0, bad = 0;

`ifdef MIPS_CPU_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  mips_cpu_state_sequencer #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .memread(memread),
    .memwrite(memwrite), .threecycle(threecycle), .pc_zero(pc_zero),
    .state(state), .active(active), .stall(stall),
    .instr_count(ic), .cycle_count(cc));

  mips_cpu_state_sequencer #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .memread(memread),
    .memwrite(memwrite), .threecycle(threecycle), .pc_zero(pc_zero),
    .state(state4), .active(active4), .stall(stall4),
    .instr_count(ic4), .cycle_count(cc4));

  // one entry per clock: inputs for the cycle plus outputs expected in it
  typedef struct {
    logic rst, rd, wr, wt, tc, pz;
    logic [2:0] st;
    logic act, stl;
  } cyc_t;

  cyc_t sb[$];
  cyc_t e;

  function automatic cyc_t mk(logic rst, logic rd, logic wr, logic wt, logic tc,
                              logic pz, logic [2:0] st, logic act, logic stl);
    cyc_t c;
    c.rst = rst; c.rd = rd; c.wr = wr; c.wt = wt; c.tc = tc; c.pz = pz;
    c.st = st; c.act = act; c.stl = stl;
    return c;
  endfunction

  task automatic apply(input cyc_t c);
    reset = c.rst; memread = c.rd; memwrite = c.wr; waitrequest = c.wt;
    threecycle = c.tc; pc_zero = c.pz;
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // plan 1: reset then three-cycle instructions
  task automatic test_reset();
    do_reset();
    sb.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0));
      sb.push_back(mk(0, 0, 0, 0, 1, 0, 2, 1, 0));
      sb.push_back(mk(0, 0, 0, 0, 1, 0, 3, 1, 0));
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); apply(e); #1;
      total++;
      if ({state, active, stall} !== {e.st, e.act, e.stl}) begin
        bad++;
        $display("FAIL reset_seq: got st=%0d act=%0b stl=%0b want st=%0d act=%0b stl=%0b",
                 state, active, stall, e.st, e.act, e.stl);
      end
    end
  endtask

  // plan 2: four-cycle instruction
  task automatic test_four_cycle();
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 3, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 4, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); apply(e); #1;
      total++;
      if ({state, active, stall} !== {e.st, e.act, e.stl}) begin
        bad++;
        $display("FAIL four_cycle: got st=%0d act=%0b stl=%0b want st=%0d act=%0b stl=%0b",
                 state, active, stall, e.st, e.act, e.stl);
      end
    end
  endtask

  // plan 3: waitrequest holds in FETCH and EXEC2, never in DECODE
  task automatic test_stall();
    sb.push_back(mk(0, 1, 0, 1, 0, 0, 2, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 3, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 4, 1, 0));
    for (int i = 0; i < 3; i++) sb.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, 1));
    sb.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 3, 1, 0));
    for (int i = 0; i < 3; i++) sb.push_back(mk(0, 0, 1, 1, 0, 0, 4, 1, 1));
    sb.push_back(mk(0, 0, 1, 0, 0, 0, 4, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); apply(e); #1;
      total++;
      if ({state, active, stall} !== {e.st, e.act, e.stl}) begin
        bad++;
        $display("FAIL stall: got st=%0d act=%0b stl=%0b want st=%0d act=%0b stl=%0b",
                 state, active, stall, e.st, e.act, e.stl);
      end
    end
  endtask

  // plan 4: halt at EXEC2 retire, pc_zero ignored elsewhere, HALT sticky
  task automatic test_halt();
    sb.push_back(mk(0, 0, 0, 0, 0, 1, 2, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 1, 3, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 1, 4, 1, 0));
    for (int i = 0; i < 10; i++)
      sb.push_back(mk(0, i[1], i[2], i[0], 0, 0, 5, 0, 0));
    sb.push_back(mk(1, 1, 0, 1, 0, 0, 5, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); apply(e); #1;
      total++;
      if ({state, active, stall} !== {e.st, e.act, e.stl}) begin
        bad++;
        $display("FAIL halt: got st=%0d act=%0b stl=%0b want st=%0d act=%0b stl=%0b",
                 state, active, stall, e.st, e.act, e.stl);
      end
    end
  endtask

  // plan 5: reset during a stalled EXEC1
  task automatic test_reset_in_stall();
    sb.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 1, 0, 2, 1, 0));
    sb.push_back(mk(0, 1, 0, 1, 1, 0, 3, 1, 1));
    sb.push_back(mk(1, 1, 0, 1, 1, 0, 3, 1, 1));
    sb.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 1, 0, 2, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 1, 0, 3, 1, 0));
    sb.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); apply(e); #1;
      total++;
      if ({state, active, stall} !== {e.st, e.act, e.stl}) begin
        bad++;
        $display("FAIL reset_in_stall: got st=%0d act=%0b stl=%0b want st=%0d act=%0b stl=%0b",
                 state, active, stall, e.st, e.act, e.stl);
      end
    end
  endtask

  // plan 6: n three-cycle instructions, halting on the last, with optional
  // two-cycle FETCH stall on instruction 1; then counter check
  task automatic test_perf(input int n, input bit stl2, input int exp_ic,
                           input int exp_cc, input int exp_ic4, input int exp_cc4);
    do_reset();
    @(negedge clk); #1;
    total++;
    if ({ic, cc, ic4, cc4} !== 72'd0) begin
      bad++;
      $display("FAIL perf_clear: got ic=%0d cc=%0d ic4=%0d cc4=%0d want 0", ic, cc, ic4, cc4);
    end
    sb.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < n; i++) begin
      if (stl2 && i == 1) begin
        sb.push_back(mk(0, 1, 0, 1, 1, 0, 1, 1, 1));
        sb.push_back(mk(0, 1, 0, 1, 1, 0, 1, 1, 1));
      end
      sb.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0));
      sb.push_back(mk(0, 0, 0, 0, 1, 0, 2, 1, 0));
      sb.push_back(mk(0, 0, 0, 0, 1, (i == n - 1), 3, 1, 0));
    end
    sb.push_back(mk(0, 1, 1, 1, 1, 1, 5, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 5, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); apply(e); #1;
      total++;
      if ({state, active, stall} !== {e.st, e.act, e.stl}) begin
        bad++;
        $display("FAIL perf_seq: got st=%0d act=%0b stl=%0b want st=%0d act=%0b stl=%0b",
                 state, active, stall, e.st, e.act, e.stl);
      end
    end
    total++;
    if (ic !== (PERF ? 32'(exp_ic) : 32'd0) || cc !== (PERF ? 32'(exp_cc) : 32'd0)) begin
      bad++;
      $display("FAIL perf_count: got ic=%0d cc=%0d want ic=%0d cc=%0d",
               ic, cc, PERF ? exp_ic : 0, PERF ? exp_cc : 0);
    end
    total++;
    if (ic4 !== (PERF ? 4'(exp_ic4) : 4'd0) || cc4 !== (PERF ? 4'(exp_cc4) : 4'd0)) begin
      bad++;
      $display("FAIL perf_wrap: got ic4=%0d cc4=%0d want ic4=%0d cc4=%0d",
               ic4, cc4, PERF ? exp_ic4 : 0, PERF ? exp_cc4 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_four_cycle();
    test_stall();
    test_halt();
    test_reset_in_stall();
    test_perf(5, 1'b0, 5, 15, 5, 15);
    test_perf(5, 1'b1, 5, 17, 5, 1);
    test_perf(17, 1'b0, 17, 51, 1, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_cpu_state_sequencer.md
Name: mips_cpu_state_sequencer

Overview:
Multicycle instruction-phase sequencer for the MIPS CPU. It sits directly upstream of the controller and drives the controller's 3-bit state input (1 = fetch, 2 = decode, 3 = exec1, 4 = exec2). It consumes the controller's threecycle/memread/memwrite outputs, the Avalon waitrequest and a datapath PC-zero flag. It stalls on memory wait, chooses 3- or 4-cycle instructions, and halts the CPU.

Parameters:
COUNT_WIDTH, 32, width of the optional performance counters

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
waitrequest  input  1  Avalon memory stall from the memory interface
memread  input  1  controller output: memory read requested this cycle
memwrite  input  1  controller output: memory write requested this cycle
threecycle  input  1  controller output: instruction completes in exec1
pc_zero  input  1  datapath: next PC to be fetched is 0x00000000 (delay slot already accounted for)
state  output  3  current phase: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2, 5 HALT
active  output  1  registered; 1 while the CPU is executing, 0 in IDLE/HALT
stall  output  1  combinational; 1 when the current state must hold (datapath gates register enables)
instr_count  output  COUNT_WIDTH  retired instruction count (optional feature only)
cycle_count  output  COUNT_WIDTH  active cycle count (optional feature only)

Behaviour:
- Reset (synchronous, overrides everything including stall): state=0 (IDLE), active=0, counters=0 at the next edge.
- stall = (memread | memwrite) & waitrequest & state∈{1,3,4}. It is forced to 0 in IDLE, DECODE and HALT.
- If stall=1, state and active hold; no transition occurs.
- Transitions when not stalled:
  - IDLE→FETCH unconditionally, one cycle after reset deasserts.
  - FETCH→DECODE.
  - DECODE→EXEC1.
  - EXEC1: threecycle=1 → FETCH, or HALT if pc_zero=1. threecycle=0 → EXEC2.
  - EXEC2 → FETCH, or HALT if pc_zero=1.
  - HALT→HALT until reset. waitrequest, memread and memwrite are ignored in HALT.
  - Illegal encodings 6/7 → IDLE on the next edge.
- active is registered from next-state: 1 iff next state ∈ {1,2,3,4}. Sequence after reset: active=0 in IDLE, 1 from the FETCH cycle onward, and 0 in the same cycle state becomes 5.
- Retire event = leaving EXEC1 (threecycle=1) or EXEC2, not stalled. One retire occurs per instruction, including the one that halts.
- pc_zero is sampled only at retire; its value in other states has no effect.
- Latency: 3 cycles per threecycle instruction and 4 otherwise, plus one cycle per stalled cycle.
- waitrequest rising and falling in the same state is handled cycle by cycle. There is no minimum stall length.

Optional Feature:
MIPS_CPU_PERF_COUNTERS_EN
- Defined:
  - instr_count increments by 1 on each retire event.
  - cycle_count increments on every cycle with active=1, including stalled cycles.
  - Both are COUNT_WIDTH wide, wrap modulo 2^COUNT_WIDTH, clear on reset and freeze in HALT.
- Undefined: no counter registers are built, and instr_count/cycle_count are driven constant 0.

Test Plan:
1. Reset 1 cycle, threecycle=1, waitrequest=0, pc_zero=0 → state 0,1,2,3,1,2,3; active 0 then 1 from the first FETCH.
2. threecycle=0 → state 1,2,3,4,1; stall=0 throughout.
3. In FETCH with memread=1, waitrequest=1 for 3 cycles → state stays 1 for 4 cycles with stall=1 for 3, then DECODE. Repeat in EXEC2 with memwrite=1 and expect the same hold.
4. pc_zero=1 at EXEC2 retire → state=5 and active=0 the next cycle; state stays 5 for 10 cycles while waitrequest/memread toggle; reset → state 0.
5. Reset asserted during a stalled EXEC1 (waitrequest=1) → state=0, active=0, counters=0 at the next edge; normal sequence resumes after release.
6. With MIPS_CPU_PERF_COUNTERS_EN: 5 three-cycle instructions, no stalls → instr_count=5, cycle_count=15. Add 2 stall cycles → cycle_count=17. With COUNT_WIDTH=4 and 17 instructions → instr_count=1 (wrap).
